// File: rtl/mdu.sv
// EX-stage multiply/divide unit holding the architectural HI/LO pair.
// Results are computed when a request is accepted and retired to HI/LO after a fixed latency.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDUOp,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic        hlSel,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] outHL,
  output logic        dbg_state_o
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam logic [4:0] MULT_N = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_N  = 5'(DIV_CYCLES);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Handshake: there is no ready; a start is taken only while busy is low,
  // and a start seen while busy is high is dropped without side effects.

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [63:0] res_q;
  logic        wr_q;
  logic        busy_q;
  logic [31:0] hi_q, lo_q;

  logic        is_mul, is_div, is_signed, div_zero;
  logic        a_neg, b_neg;
  logic [31:0] abs_a, abs_b, div_b;
  logic [31:0] q_u, r_u, quot, rem;
  logic [63:0] ext_a, ext_b, prod;
  logic [63:0] res_d;

  always_comb begin
    is_mul    = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
    is_div    = (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);
    is_signed = (MDUOp == OP_MULT) || (MDUOp == OP_DIV);
    div_zero  = (srcB == 32'd0);

    // Sign-extend for signed multiply; low 64 bits of the product are exact.
    ext_a = is_signed ? {{32{srcA[31]}}, srcA} : {32'd0, srcA};
    ext_b = is_signed ? {{32{srcB[31]}}, srcB} : {32'd0, srcB};
    prod  = ext_a * ext_b;

    // Signed divide on magnitudes; handles 0x80000000 / -1 without overflow.
    a_neg = is_signed & srcA[31];
    b_neg = is_signed & srcB[31];
    abs_a = a_neg ? (32'd0 - srcA) : srcA;
    abs_b = b_neg ? (32'd0 - srcB) : srcB;
    div_b = div_zero ? 32'd1 : abs_b;
    q_u   = abs_a / div_b;
    r_u   = abs_a % div_b;
    quot  = (a_neg ^ b_neg) ? (32'd0 - q_u) : q_u;
    rem   = a_neg ? (32'd0 - r_u) : r_u;

    res_d = is_div ? {rem, quot} : prod;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      res_q   <= 64'd0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (is_mul || is_div) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              cnt_q   <= is_mul ? MULT_N : DIV_N;
              res_q   <= res_d;
              wr_q    <= !(is_div && div_zero);
            end else if (MDUOp == OP_MTHI) begin
              hi_q <= srcA;
            end else if (MDUOp == OP_MTLO) begin
              lo_q <= srcA;
            end
          end
        end
        RUN: begin
          if (cnt_q <= 5'd1) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= 5'd0;
            if (wr_q) begin
              hi_q <= res_q[63:32];
              lo_q <= res_q[31:0];
            end
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign HI          = hi_q;
  assign LO          = lo_q;
  assign outHL       = hlSel ? hi_q : lo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: hand-computed vectors for mult/div/mthi/mtlo, busy length,
// ignored starts, back-to-back issue and asynchronous reset mid-operation.
module tb_mdu;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  MDUOp;
  logic [31:0] srcA, srcB;
  logic        hlSel;
  logic        busy;
  logic [31:0] HI, LO, outHL;
  logic        dbg_state;

  int vectors = 0;
  int errs    = 0;
  int n;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .MDUOp(MDUOp),
    .srcA(srcA), .srcB(srcB), .hlSel(hlSel), .busy(busy),
    .HI(HI), .LO(LO), .outHL(outHL), .dbg_state_o(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge with the given op; returns just after that edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    MDUOp = op;
    srcA  = a;
    srcB  = b;
    tick();
    start = 1'b0;
    MDUOp = 3'b000;
  endtask

  // Count cycles busy stays high, bounded so a stuck busy cannot hang the run.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 64) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; MDUOp = 3'b000;
    srcA = 32'd0; srcB = 32'd0; hlSel = 1'b0;
    #22;
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_state", {31'd0, dbg_state}, 32'h0);
    reset = 1'b1;
    tick();

    issue(3'b001, 32'd5, 32'd7);
    chk("mult_busy_now", {31'd0, busy}, 32'h1);
    wait_idle(n);
    chk("mult_busy_len", n, 32'd5);
    chk("mult57_hi", HI, 32'h0);
    chk("mult57_lo", LO, 32'h23);
    hlSel = 1'b0; #1;
    chk("outhl_lo", outHL, 32'h23);
    hlSel = 1'b1; #1;
    chk("outhl_hi", outHL, 32'h0);
    hlSel = 1'b0;

    issue(3'b001, 32'hFFFFFFFF, 32'd2);
    wait_idle(n);
    chk("mult_neg_hi", HI, 32'hFFFFFFFF);
    chk("mult_neg_lo", LO, 32'hFFFFFFFE);
    issue(3'b010, 32'hFFFFFFFF, 32'd2);
    wait_idle(n);
    chk("multu_hi", HI, 32'h00000001);
    chk("multu_lo", LO, 32'hFFFFFFFE);

    issue(3'b011, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    chk("div_busy_len", n, 32'd10);
    chk("div_lo", LO, 32'hFFFFFFFD);
    chk("div_hi", HI, 32'hFFFFFFFF);
    issue(3'b100, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    chk("divu_lo", LO, 32'h7FFFFFFC);
    chk("divu_hi", HI, 32'h00000001);
    issue(3'b011, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    chk("div_ovf_lo", LO, 32'h80000000);
    chk("div_ovf_hi", HI, 32'h0);

    issue(3'b101, 32'h12345678, 32'd0);
    chk("mthi_hi", HI, 32'h12345678);
    chk("mthi_lo_kept", LO, 32'h80000000);
    chk("mthi_busy", {31'd0, busy}, 32'h0);
    issue(3'b110, 32'h9ABCDEF0, 32'd0);
    chk("mtlo_lo", LO, 32'h9ABCDEF0);
    chk("mtlo_hi_kept", HI, 32'h12345678);
    chk("mtlo_busy", {31'd0, busy}, 32'h0);

    issue(3'b100, 32'd5, 32'd0);
    wait_idle(n);
    chk("div0_busy_len", n, 32'd10);
    chk("div0_hi", HI, 32'h12345678);
    chk("div0_lo", LO, 32'h9ABCDEF0);

    issue(3'b111, 32'h11111111, 32'd3);
    chk("rsvd_busy", {31'd0, busy}, 32'h0);
    chk("rsvd_hi", HI, 32'h12345678);
    issue(3'b000, 32'h22222222, 32'd3);
    chk("nop_lo", LO, 32'h9ABCDEF0);

    issue(3'b001, 32'd3, 32'd3);
    tick();
    issue(3'b101, 32'hDEADBEEF, 32'd0);
    chk("ign_hi_mid", HI, 32'h12345678);
    wait_idle(n);
    chk("ign_busy_len", n + 2, 32'd5);
    chk("ign_hi", HI, 32'h0);
    chk("ign_lo", LO, 32'h9);

    issue(3'b001, 32'd6, 32'd7);
    chk("b2b_busy", {31'd0, busy}, 32'h1);
    wait_idle(n);
    chk("b2b_len", n, 32'd5);
    chk("b2b_lo", LO, 32'h2A);
    chk("b2b_hi", HI, 32'h0);

    issue(3'b011, 32'd100, 32'd7);
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("arst_hi", HI, 32'h0);
    chk("arst_lo", LO, 32'h0);
    chk("arst_busy", {31'd0, busy}, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    chk("post_hi", HI, 32'h0);
    chk("post_lo", LO, 32'h0);
    chk("post_busy", {31'd0, busy}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
